// File: rtl/tracesys_pkg.sv
// Shared trace-system definitions: stream widths, channel ids and the packet-mux FSM states.
package tracesys_pkg;

    localparam int unsigned TRACESYS_DATA_W    = 8;
    // Demux payload is {data, eop, sop}
    localparam int unsigned TRACESYS_PAYLOAD_W = 10;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/tracesys_pkt_mux_out_stage.sv
// Single buffered output register of the packet mux; payload is {channel, data, eop, sop}.
module tracesys_pkt_mux_out_stage #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] beat,
    input  logic             out_ready,
    output logic             stage_ready_c,
    output logic             valid,
    output logic [WIDTH-1:0] payload
);

    assign stage_ready_c = out_ready || !valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid   <= 1'b0;
            payload <= '0;
        end else begin
            if (load) begin
                valid   <= 1'b1;
                payload <= beat;
            end else if (out_ready) begin
                valid   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tracesys_pkt_mux.sv
// 2:1 packet-atomic round-robin mux for the trace byte streams, channel-tagged for the demux.
// Optional per-source packet counters: define TRACESYS_PKT_MUX_PKT_COUNT_EN.
module tracesys_pkt_mux
    import tracesys_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = TRACESYS_DATA_W
`ifdef TRACESYS_PKT_MUX_PKT_COUNT_EN
    ,
    parameter int unsigned CNT_WIDTH  = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in0_valid,
    output logic                  in0_ready,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic                  in0_startofpacket,
    input  logic                  in0_endofpacket,
    input  logic                  in1_valid,
    output logic                  in1_ready,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic                  in1_startofpacket,
    input  logic                  in1_endofpacket,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_channel,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_startofpacket,
`ifdef TRACESYS_PKT_MUX_PKT_COUNT_EN
    output logic [CNT_WIDTH-1:0]  pkt_count0,
    output logic [CNT_WIDTH-1:0]  pkt_count1,
`endif
    output logic                  out_endofpacket
);

    // Demux sideband bits (eop, sop) plus the channel tag around the data
    localparam int unsigned STAGE_W = DATA_WIDTH + (TRACESYS_PAYLOAD_W - TRACESYS_DATA_W) + 1;

    state_t state, state_nxt;
    logic   lock_ch, lock_ch_nxt;
    logic   last_grant, last_grant_nxt;

    logic   grant;
    logic   sel_valid;
    logic   sel_eop;
    logic   accept;
    logic   stage_ready;
    logic [STAGE_W-1:0] stage_beat;
    logic [STAGE_W-1:0] stage_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            lock_ch    <= CH0;
            last_grant <= CH1;
        end else begin
            state      <= state_nxt;
            lock_ch    <= lock_ch_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Grant selection, readies and packet-boundary tracking
    always_comb begin
        grant          = CH0;
        sel_valid      = 1'b0;
        in0_ready      = 1'b0;
        in1_ready      = 1'b0;
        state_nxt      = state;
        lock_ch_nxt    = lock_ch;
        last_grant_nxt = last_grant;

        if (state == LOCKED) begin
            grant     = lock_ch;
            sel_valid = (lock_ch == CH1) ? in1_valid : in0_valid;
            in0_ready = stage_ready && (lock_ch == CH0);
            in1_ready = stage_ready && (lock_ch == CH1);
        end else begin
            if (in0_valid && in1_valid) begin
                grant = ~last_grant;
            end else if (in1_valid) begin
                grant = CH1;
            end
            sel_valid = in0_valid || in1_valid;
            in0_ready = stage_ready && sel_valid && (grant == CH0);
            in1_ready = stage_ready && sel_valid && (grant == CH1);
        end

        if (accept) begin
            if (sel_eop) begin
                state_nxt      = IDLE;
                last_grant_nxt = grant;
            end else begin
                state_nxt      = LOCKED;
                lock_ch_nxt    = grant;
            end
        end
    end

    assign accept     = sel_valid && stage_ready;
    assign sel_eop    = (grant == CH1) ? in1_endofpacket : in0_endofpacket;
    assign stage_beat = (grant == CH1)
                      ? {CH1, in1_data, in1_endofpacket, in1_startofpacket}
                      : {CH0, in0_data, in0_endofpacket, in0_startofpacket};

    tracesys_pkt_mux_out_stage #(
        .WIDTH (STAGE_W)
    ) u_out_stage (
        .clk           (clk),
        .reset_n       (reset_n),
        .load          (accept),
        .beat          (stage_beat),
        .out_ready     (out_ready),
        .stage_ready_c (stage_ready),
        .valid         (out_valid),
        .payload       (stage_q)
    );

    assign out_channel       = stage_q[STAGE_W-1];
    assign out_data          = stage_q[STAGE_W-2 -: DATA_WIDTH];
    assign out_endofpacket   = stage_q[1];
    assign out_startofpacket = stage_q[0];

`ifdef TRACESYS_PKT_MUX_PKT_COUNT_EN
    // Completed packets per source, wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_count0 <= '0;
            pkt_count1 <= '0;
        end else if (accept && sel_eop) begin
            if (grant == CH1) begin
                pkt_count1 <= pkt_count1 + CNT_WIDTH'(1);
            end else begin
                pkt_count0 <= pkt_count0 + CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_tracesys_pkt_mux.sv
// Self-checking bench for tracesys_pkt_mux: packet-level model plus directed packet sequences.
module tb_tracesys_pkt_mux;

    typedef struct packed {
        logic       ch;
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in0_valid = 1'b0, in0_ready;
    logic [7:0] in0_data = 8'h00;
    logic       in0_sop = 1'b0, in0_eop = 1'b0;
    logic       in1_valid = 1'b0, in1_ready;
    logic [7:0] in1_data = 8'h00;
    logic       in1_sop = 1'b0, in1_eop = 1'b0;
    logic       out_valid, out_channel, out_sop, out_eop;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
`ifdef TRACESYS_PKT_MUX_PKT_COUNT_EN
    logic [15:0] pkt_count0, pkt_count1;
`endif

    int errors = 0;
    int checks = 0;

    beat_t q0[$];
    beat_t q1[$];
    beat_t exp_q[$];

    tracesys_pkt_mux dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in0_valid         (in0_valid),
        .in0_ready         (in0_ready),
        .in0_data          (in0_data),
        .in0_startofpacket (in0_sop),
        .in0_endofpacket   (in0_eop),
        .in1_valid         (in1_valid),
        .in1_ready         (in1_ready),
        .in1_data          (in1_data),
        .in1_startofpacket (in1_sop),
        .in1_endofpacket   (in1_eop),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_channel       (out_channel),
        .out_data          (out_data),
        .out_startofpacket (out_sop),
`ifdef TRACESYS_PKT_MUX_PKT_COUNT_EN
        .pkt_count0        (pkt_count0),
        .pkt_count1        (pkt_count1),
`endif
        .out_endofpacket   (out_eop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic beat_t mk(input logic ch, input logic [7:0] d, input logic s, input logic e);
        beat_t b;
        b.ch = ch; b.data = d; b.sop = s; b.eop = e;
        return b;
    endfunction

    // Push a beat to its source queue and to the expected output order
    task automatic send(input logic ch, input logic [7:0] d, input logic s, input logic e, input bit expect_it);
        if (ch) q1.push_back(mk(ch, d, s, e));
        else    q0.push_back(mk(ch, d, s, e));
        if (expect_it) exp_q.push_back(mk(ch, d, s, e));
    endtask

    // Packet-level model: output register holds the last accepted beat; a packet
    // owns the output from its first beat to its EOP; ties go away from the last finisher.
    logic  m_valid = 1'b0, m_open = 1'b0, m_open_ch = 1'b0, m_last = 1'b1;
    beat_t m_beat = '0;
    logic  c_srdy, c_er0, c_er1, c_a0, c_a1;
    beat_t c_got;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_valid = 1'b0; m_beat = '0; m_open = 1'b0; m_open_ch = 1'b0; m_last = 1'b1;
        end else begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid)
                check("out_beat", 32'({out_channel, out_data, out_sop, out_eop}), 32'(m_beat));
            c_srdy = out_ready || !m_valid;
            c_er0 = 1'b0; c_er1 = 1'b0;
            if (c_srdy) begin
                if (m_open) begin
                    c_er0 = !m_open_ch; c_er1 = m_open_ch;
                end else if (in0_valid && in1_valid) begin
                    c_er0 = m_last; c_er1 = !m_last;
                end else begin
                    c_er0 = in0_valid; c_er1 = in1_valid;
                end
            end
            check("readies", 32'({in0_ready, in1_ready}), 32'({c_er0, c_er1}));
            c_a0 = in0_valid && in0_ready;
            c_a1 = in1_valid && in1_ready;
            if (c_a0 || c_a1) begin
                c_got = c_a1 ? mk(1'b1, in1_data, in1_sop, in1_eop) : mk(1'b0, in0_data, in0_sop, in0_eop);
                if (exp_q.size() == 0) check("beat_order_len", 32'(exp_q.size()), 32'd1);
                else                   check("beat_order", 32'(c_got), 32'(exp_q.pop_front()));
                m_valid = 1'b1;
                m_beat  = c_got;
                if (c_got.eop) begin
                    m_open = 1'b0; m_last = c_got.ch;
                end else begin
                    m_open = 1'b1; m_open_ch = c_got.ch;
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic drive_heads();
        in0_valid = (q0.size() > 0);
        if (q0.size() > 0) begin
            in0_data = q0[0].data; in0_sop = q0[0].sop; in0_eop = q0[0].eop;
        end
        in1_valid = (q1.size() > 0);
        if (q1.size() > 0) begin
            in1_data = q1[0].data; in1_sop = q1[0].sop; in1_eop = q1[0].eop;
        end
    endtask

    task automatic run_cycle(input logic ordy);
        logic a0, a1;
        out_ready = ordy;
        drive_heads();
        @(negedge clk);
        a0 = in0_valid && in0_ready;
        a1 = in1_valid && in1_ready;
        @(posedge clk);
        #1;
        if (a0) q0.delete(0);
        if (a1) q1.delete(0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && n < 60) begin
            run_cycle(1'b1);
            n++;
        end
        run_cycle(1'b1);
        run_cycle(1'b1);
        check({name, "_drained"}, 32'(q0.size() + q1.size() + exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b1;
        q0.delete(); q1.delete(); exp_q.delete();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_channel", 32'(out_channel), 32'd0);
        check("rst_sop_eop", 32'({out_sop, out_eop}), 32'd0);

        // Single source-0 packet, one-cycle latency
        send(1'b0, 8'hA1, 1'b1, 1'b0, 1'b1);
        send(1'b0, 8'hA2, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'hA3, 1'b0, 1'b1, 1'b1);
        run_cycle(1'b1);
        check("t1_latency", 32'({out_valid, out_channel, out_data, out_sop, out_eop}), 32'({1'b1, 1'b0, 8'hA1, 1'b1, 1'b0}));
        drain("t1");

        // Simultaneous 2-beat packets: source 0 wins the first tie
        do_reset();
        send(1'b0, 8'hB1, 1'b1, 1'b0, 1'b1);
        send(1'b0, 8'hB2, 1'b0, 1'b1, 1'b1);
        send(1'b1, 8'hC1, 1'b1, 1'b0, 1'b1);
        send(1'b1, 8'hC2, 1'b0, 1'b1, 1'b1);
        drain("t2");

        // Source 1 arrives mid-packet and must wait for source-0 EOP
        do_reset();
        send(1'b0, 8'hD1, 1'b1, 1'b0, 1'b1);
        send(1'b0, 8'hD2, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'hD3, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'hD4, 1'b0, 1'b1, 1'b1);
        exp_q.push_back(mk(1'b1, 8'hE1, 1'b1, 1'b1));
        run_cycle(1'b1);
        run_cycle(1'b1);
        q1.push_back(mk(1'b1, 8'hE1, 1'b1, 1'b1));
        drain("t3");

        // Backpressure for 5 cycles mid-packet
        do_reset();
        send(1'b0, 8'hF1, 1'b1, 1'b0, 1'b1);
        send(1'b0, 8'hF2, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'hF3, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'hF4, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'hF5, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            run_cycle((i >= 2 && i < 7) ? 1'b0 : 1'b1);
            if (i == 6) check("t4_hold", 32'({out_valid, out_data}), 32'({1'b1, 8'hF2}));
        end
        drain("t4");

        // Single-beat packets on both sources alternate at full rate
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 8'(8'h10 + i), 1'b1, 1'b1, 1'b0);
            send(1'b1, 8'(8'h20 + i), 1'b1, 1'b1, 1'b0);
            exp_q.push_back(mk(1'b0, 8'(8'h10 + i), 1'b1, 1'b1));
            exp_q.push_back(mk(1'b1, 8'(8'h20 + i), 1'b1, 1'b1));
        end
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 20) begin
            run_cycle(1'b1);
            n++;
        end
        check("t5_cycles", 32'(n), 32'd6);
        drain("t5");

        // Reset mid source-1 packet, then a tie grants source 0
        do_reset();
        send(1'b1, 8'h31, 1'b1, 1'b0, 1'b1);
        send(1'b1, 8'h32, 1'b0, 1'b0, 1'b1);
        send(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        send(1'b1, 8'h34, 1'b0, 1'b1, 1'b0);
        run_cycle(1'b1);
        run_cycle(1'b1);
        check("t6_pre_reset", 32'({out_valid, out_channel, out_data}), 32'({1'b1, 1'b1, 8'h32}));
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_clear", 32'(out_valid), 32'd0);
        check("t6_exp_consumed", 32'(exp_q.size()), 32'd0);
        in1_valid = 1'b0;
        q1.delete();
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
`ifdef TRACESYS_PKT_MUX_PKT_COUNT_EN
        check("t6_cnt0_reset", 32'(pkt_count0), 32'd0);
`endif
        send(1'b0, 8'h41, 1'b1, 1'b1, 1'b1);
        send(1'b1, 8'h51, 1'b1, 1'b1, 1'b1);
        q0.push_back(mk(1'b0, 8'h42, 1'b1, 1'b1));
        q0.push_back(mk(1'b0, 8'h43, 1'b1, 1'b1));
        exp_q.push_back(mk(1'b0, 8'h42, 1'b1, 1'b1));
        exp_q.push_back(mk(1'b0, 8'h43, 1'b1, 1'b1));
        run_cycle(1'b1);
        check("t6_tie_to_src0", 32'({out_valid, out_channel, out_data}), 32'({1'b1, 1'b0, 8'h41}));
        drain("t6");
`ifdef TRACESYS_PKT_MUX_PKT_COUNT_EN
        check("t6_cnt0", 32'(pkt_count0), 32'd3);
        check("t6_cnt1", 32'(pkt_count1), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
